// File: rtl/uart_host_ctrl.sv
// Host-side initiator for the UART divider link: sends CMD,op_a,CMD,op_b with timed pacing,
// then collects a big-endian multi-byte reply with a timeout.
module uart_host_ctrl #(
  parameter logic [7:0]  CMD_BYTE       = 8'h73,
  parameter int unsigned GAP_CYCLES     = 57288,
  parameter int unsigned RESP_BYTES     = 3,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [7:0]              op_a,
  input  logic [7:0]              op_b,
  output logic [7:0]              tx_data,
  output logic                    tx_ready,
  input  logic [7:0]              rx_data,
  input  logic                    rx_ready,
  output logic [8*RESP_BYTES-1:0] result,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int unsigned ResW = 8 * RESP_BYTES;
  localparam int unsigned GapW = $clog2(GAP_CYCLES + 1);
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned RcW  = $clog2(RESP_BYTES + 1);

  typedef enum logic [2:0] {StIdle, StSend, StGap, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic [7:0]        op_a_q, op_a_d, op_b_q, op_b_d;
  logic [1:0]        bi_q, bi_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic [RcW-1:0]    rc_q, rc_d;
  logic [ResW-1:0]   shadow_q, shadow_d;
  logic              err_flag_q, err_flag_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_ready_q, tx_ready_d;
  logic [ResW-1:0]   result_q, result_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  // Outputs are registered, so they trail the state register by one clock.
  always_comb begin
    state_d    = state_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    bi_d       = bi_q;
    gap_d      = gap_q;
    tmo_d      = tmo_q;
    rc_d       = rc_q;
    shadow_d   = shadow_q;
    err_flag_d = err_flag_q;
    tx_data_d  = tx_data_q;
    tx_ready_d = 1'b0;
    result_d   = result_q;
    busy_d     = (state_q != StIdle);
    done_d     = 1'b0;
    err_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_a_d  = op_a;
          op_b_d  = op_b;
          bi_d    = 2'd0;
          state_d = StSend;
        end
      end
      StSend: begin
        case (bi_q)
          2'd1:    tx_data_d = op_a_q;
          2'd3:    tx_data_d = op_b_q;
          default: tx_data_d = CMD_BYTE;
        endcase
        tx_ready_d = 1'b1;
        gap_d      = '0;
        state_d    = StGap;
      end
      StGap: begin
        if (gap_q == GapW'(GAP_CYCLES - 1)) begin
          if (bi_q == 2'd3) begin
            rc_d       = '0;
            tmo_d      = '0;
            err_flag_d = 1'b0;
            state_d    = StWait;
          end else begin
            bi_d    = bi_q + 2'd1;
            state_d = StSend;
          end
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      StWait: begin
        if (rx_ready) begin
          shadow_d = {shadow_q[ResW-9:0], rx_data};
          rc_d     = rc_q + RcW'(1);
        end
        // A final byte arriving on the expiry cycle still counts as success.
        if (rx_ready && (rc_q == RcW'(RESP_BYTES - 1))) begin
          err_flag_d = 1'b0;
          state_d    = StDone;
        end else if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
          err_flag_d = 1'b1;
          state_d    = StDone;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StDone: begin
        done_d = 1'b1;
        err_d  = err_flag_q;
        if (!err_flag_q) begin
          result_d = shadow_q;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      op_a_q     <= '0;
      op_b_q     <= '0;
      bi_q       <= '0;
      gap_q      <= '0;
      tmo_q      <= '0;
      rc_q       <= '0;
      shadow_q   <= '0;
      err_flag_q <= 1'b0;
      tx_data_q  <= '0;
      tx_ready_q <= 1'b0;
      result_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      bi_q       <= bi_d;
      gap_q      <= gap_d;
      tmo_q      <= tmo_d;
      rc_q       <= rc_d;
      shadow_q   <= shadow_d;
      err_flag_q <= err_flag_d;
      tx_data_q  <= tx_data_d;
      tx_ready_q <= tx_ready_d;
      result_q   <= result_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_ready = tx_ready_q;
  assign result   = result_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_uart_host_ctrl.sv
// Bench for uart_host_ctrl: timestamp-based reference model checked every cycle, plus
// directed frames with hand-computed results and timings.
module tb_uart_host_ctrl;

  localparam int unsigned G = 20;
  localparam int unsigned T = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b1;
  logic [7:0]  op_a = 8'h00;
  logic [7:0]  op_b = 8'h00;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready = 1'b0;
  logic [23:0] result;
  logic        busy;
  logic        done;
  logic        err;

  uart_host_ctrl #(
    .CMD_BYTE      (8'h73),
    .GAP_CYCLES    (G),
    .RESP_BYTES    (3),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op_a    (op_a),
    .op_b    (op_b),
    .tx_data (tx_data),
    .tx_ready(tx_ready),
    .rx_data (rx_data),
    .rx_ready(rx_ready),
    .result  (result),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [7:0] frame_byte(int unsigned idx, logic [7:0] a, logic [7:0] b);
    if (idx == 1) return a;
    if (idx == 3) return b;
    return 8'h73;
  endfunction

  // Reference model: everything derives from the edge at which start was accepted.
  int unsigned cyc = 0;
  bit          m_valid = 0, m_active = 0, m_fin = 0, m_ok = 0;
  int unsigned m_n, m_w, m_f, m_cnt, m_k;
  logic [7:0]  m_a, m_b;
  logic [23:0] m_sh;
  logic [7:0]  e_txd;
  logic [23:0] e_result;
  logic        e_txr, e_busy, e_done, e_err;

  always begin
    @(posedge clk);
    cyc++;
    e_txr  = 1'b0;
    e_done = 1'b0;
    e_err  = 1'b0;
    if (!rst) begin
      m_valid  = 1;
      m_active = 0;
      e_txd    = 8'h00;
      e_result = 24'h0;
      e_busy   = 1'b0;
    end else begin
      if (m_active && m_fin && cyc == m_f + 2) m_active = 0;
      if (!m_active) begin
        if (start) begin
          m_active = 1;
          m_fin    = 0;
          m_n      = cyc;
          m_w      = cyc + 4 * (G + 1);
          m_cnt    = 0;
          m_a      = op_a;
          m_b      = op_b;
        end
      end else begin
        m_k = cyc - m_n - 1;
        if (m_k % (G + 1) == 0 && m_k / (G + 1) < 4) begin
          e_txr = 1'b1;
          e_txd = frame_byte(m_k / (G + 1), m_a, m_b);
        end
        if (!m_fin && cyc > m_w) begin
          if (rx_ready) begin
            m_sh = {m_sh[15:0], rx_data};
            m_cnt++;
          end
          if (m_cnt == 3) begin
            m_fin = 1; m_ok = 1; m_f = cyc;
          end else if (cyc == m_w + T) begin
            m_fin = 1; m_ok = 0; m_f = cyc;
          end
        end
        if (m_fin && cyc == m_f + 1) begin
          e_done = 1'b1;
          e_err  = !m_ok;
          if (m_ok) e_result = m_sh;
        end
      end
      e_busy = m_active && (cyc > m_n);
    end
  end

  logic [7:0]  txq[$];
  int unsigned txt[$];

  always begin
    @(negedge clk);
    if (m_valid) begin
      check("tx_ready", 32'(tx_ready), 32'(e_txr));
      check("tx_data",  32'(tx_data),  32'(e_txd));
      check("busy",     32'(busy),     32'(e_busy));
      check("done",     32'(done),     32'(e_done));
      check("err",      32'(err),      32'(e_err));
      check("result",   32'(result),   32'(e_result));
    end
    if (tx_ready) begin
      txq.push_back(tx_data);
      txt.push_back(cyc);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_tx(int unsigned n);
    int unsigned i = 0;
    while (txq.size() < n && i < 400) begin
      step();
      i++;
    end
    check("tx_pulse_count", 32'(txq.size()), 32'(n));
  endtask

  task automatic wait_done(output int unsigned t);
    int unsigned i = 0;
    while (!done && i < 1000) begin
      step();
      i++;
    end
    check("done_seen", 32'(done), 32'd1);
    t = cyc;
  endtask

  // Sample rx byte at edge x.
  task automatic drive_at(int unsigned x, logic [7:0] b);
    while (cyc + 1 < x) step();
    rx_data  = b;
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
  endtask

  task automatic run_frame(logic [7:0] a, logic [7:0] b, output int unsigned p);
    txq.delete();
    txt.delete();
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    step();
    start = 1'b0;
    op_a  = 8'hFF;
    op_b  = 8'hEE;
    wait_tx(4);
    p = (txt.size() == 4) ? txt[3] : cyc;
  endtask

  task automatic check_frame(logic [7:0] a, logic [7:0] b);
    if (txq.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("frame_byte", 32'(txq[i]), 32'(frame_byte(i, a, b)));
      end
      for (int i = 0; i < 3; i++) begin
        check("pulse_spacing", 32'(txt[i+1] - txt[i]), 32'd21);
      end
    end
  endtask

  int unsigned p, t;

  initial begin
    // Reset with start held high.
    step();
    step();
    check("rst_tx_ready", 32'(tx_ready), 32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_result",   32'(result),   32'd0);
    rst   = 1'b1;
    start = 1'b0;
    step();
    check("post_rst_busy", 32'(busy), 32'd0);

    // Nominal 3 / 1 -> 300.
    run_frame(8'h03, 8'h01, p);
    check_frame(8'h03, 8'h01);
    drive_at(p + 21, 8'h00);
    drive_at(p + 22, 8'h01);
    drive_at(p + 23, 8'h2C);
    wait_done(t);
    check("nom_done_lat", 32'(t - p), 32'd24);
    check("nom_result",   32'(result), 32'h00012C);
    check("nom_err",      32'(err), 32'd0);
    step();
    check("nom_done_width", 32'(done), 32'd0);
    step();
    step();

    // Timeout: no reply.
    run_frame(8'h05, 8'h06, p);
    wait_done(t);
    check("tmo_done_lat", 32'(t - p), 32'd221);
    check("tmo_err",      32'(err), 32'd1);
    check("tmo_result",   32'(result), 32'h00012C);
    step();
    step();

    // Stray bytes while idle and in gap, plus an extra 4th reply byte.
    drive_at(cyc + 1, 8'h99);
    run_frame(8'h12, 8'h34, p);
    check_frame(8'h12, 8'h34);
    drive_at(p + 5,  8'hAA);
    drive_at(p + 21, 8'hDE);
    drive_at(p + 22, 8'hAD);
    drive_at(p + 23, 8'hBE);
    drive_at(p + 24, 8'h55);
    wait_done(t);
    check("stray_result", 32'(result), 32'hDEADBE);
    check("stray_err",    32'(err), 32'd0);

    // Back-to-back start; third byte lands on the timeout expiry edge.
    run_frame(8'h07, 8'h08, p);
    check("b2b_frame", 32'(txq.size()), 32'd4);
    drive_at(p + 21,  8'h11);
    drive_at(p + 22,  8'h22);
    drive_at(p + 220, 8'h33);
    wait_done(t);
    check("edge_done_lat", 32'(t - p), 32'd221);
    check("edge_err",      32'(err), 32'd0);
    check("edge_result",   32'(result), 32'h112233);
    step();
    step();

    // Start re-pulsed mid-frame, then reset after the second byte.
    txq.delete();
    txt.delete();
    op_a  = 8'h09;
    op_b  = 8'h0A;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_tx(1);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_tx(2);
    rst = 1'b0;
    step();
    rst = 1'b1;
    repeat (60) step();
    check("abort_pulses", 32'(txq.size()), 32'd2);
    check("abort_busy",   32'(busy), 32'd0);
    check("abort_result", 32'(result), 32'd0);

    // Fresh full frame after the abort.
    run_frame(8'h21, 8'h22, p);
    check_frame(8'h21, 8'h22);
    drive_at(p + 21, 8'h01);
    drive_at(p + 22, 8'h02);
    drive_at(p + 23, 8'h03);
    wait_done(t);
    check("fresh_result", 32'(result), 32'h010203);
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

endmodule

// File: doc/uart_host_ctrl.md
# uart_host_ctrl

Host-side command initiator for the UART divider link. It is the counterpart of the board controller that receives `'s'`-prefixed operand bytes and returns a 24-bit quotient. On `start` it sends the frame `CMD, op_a, CMD, op_b` through a `tx_uart` byte interface, then collects a 3-byte big-endian reply from an `rx_uart` byte interface. It sits between a test/host sequencer and one `tx_uart` plus one `rx_uart` instance.

## Interface
Parameters:
- `CMD_BYTE`, 8'h73, prefix byte sent before each operand
- `GAP_CYCLES`, 57288, clocks reserved per transmitted byte (11 bit times at 50 MHz / 9600 baud); `tx_uart` has no busy flag, so pacing is timed here
- `RESP_BYTES`, 3, reply length in bytes (fixed at 3; `result` width is 8*`RESP_BYTES`)
- `TIMEOUT_CYCLES`, 2_000_000, maximum clocks to wait for the full reply

Ports:
- `clk`  in  1  system clock, 50 MHz
- `rst`  in  1  synchronous, active-low reset
- `start`  in  1  request pulse; sampled only in IDLE
- `op_a`  in  8  first operand; latched on accepted `start`
- `op_b`  in  8  second operand; latched on accepted `start`
- `tx_data`  out  8  byte to `tx_uart`
- `tx_ready`  out  1  one-cycle send strobe to `tx_uart`
- `rx_data`  in  8  byte from `rx_uart`
- `rx_ready`  in  1  one-cycle byte-valid strobe from `rx_uart`
- `result`  out  24  assembled reply, MSB byte first
- `busy`  out  1  high from accepted `start` until `done`
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  one-cycle, coincident with `done` on timeout

## Operation
- States:
  - IDLE → SEND on `start`=1; `op_a`/`op_b` latched, byte index `bi`=0.
  - SEND: drive `tx_data`=byte[`bi`] with `tx_ready`=1 for exactly one cycle. Byte sequence is `CMD_BYTE`, `op_a`, `CMD_BYTE`, `op_b`. Go to GAP.
  - GAP: count `GAP_CYCLES`. At terminal count, go to SEND with `bi`+1 if `bi`<3, otherwise go to WAIT_RESP with reply count `rc`=0 and timeout counter cleared.
  - WAIT_RESP: each `rx_ready` shifts `rx_data` into `result` from the LSB end (`result` <= {`result`[15:0], `rx_data`}) and increments `rc`. When `rc` reaches 3, go to DONE. If the timeout counter reaches `TIMEOUT_CYCLES`-1 first, go to DONE with the error flag set.
  - DONE: `done`=1 for one cycle, `err`=error flag, then return to IDLE.
- `result` is built in a shadow register and copied to the output only on a successful DONE. On timeout `result` keeps its previous value.
- Boundary conditions:
  - `start` while `busy`: ignored.
  - `rx_ready` outside WAIT_RESP: discarded. Stray echo bytes during send never corrupt the reply.
  - `rx_ready` in the same cycle the timeout expires: the byte wins. If it is the third byte, the result is a success.
  - Extra reply bytes after the third are ignored.
  - `op_a`/`op_b` changing mid-frame: no effect.
  - `rst`=0 at any clock edge: all state cleared, next state IDLE, any send aborted. `tx_ready` is never left high.

## Timing
- Reset values: `tx_data`=0, `tx_ready`=0, `result`=0, `busy`=0, `done`=0, `err`=0.
- `start` sampled at edge N → `busy`=1 and first `tx_ready` pulse (`tx_data`=0x73) both visible after edge N+1.
- Successive `tx_ready` pulses are exactly `GAP_CYCLES`+1 clocks apart. The 4th pulse is followed by `GAP_CYCLES` clocks before WAIT_RESP.
- `tx_data` holds its value from the strobe cycle until the next SEND.
- Third `rx_ready` at edge M → `result` updated and `done`=1 after edge M+1 → `busy`=0 after edge M+2.
- Timeout: `done`=`err`=1 exactly `TIMEOUT_CYCLES`+1 clocks after entering WAIT_RESP.
- Minimum idle between transactions: one cycle, with `start` accepted in the cycle after `done`.

## Test plan
Bench parameters: `GAP_CYCLES`=20, `TIMEOUT_CYCLES`=200.
- Reset: hold `rst`=0 for 2 cycles → all outputs 0. `start` held high during reset → no `tx_ready`.
- Nominal: `op_a`=0x03, `op_b`=0x01, pulse `start` → `tx_ready` pulses carry 0x73, 0x03, 0x73, 0x01, spaced 21 clocks apart. Then feed 0x00, 0x01, 0x2C → `result`=0x00012C, `done`=1 for one cycle, `err`=0.
- Timeout: no reply bytes → `done`=`err`=1 at 201 clocks after WAIT_RESP entry, with `result` unchanged from the previous run.
- Stray/extra bytes: inject 0xAA during GAP and a 4th reply byte 0x55 → `result` reflects only the 3 WAIT_RESP bytes.
- Busy/abort: `start` re-pulsed mid-frame → ignored. `rst`=0 after the 2nd `tx_ready` → IDLE, no further `tx_ready`. A fresh `start` then runs a full 4-byte frame.
- End-to-end: drive `tx_data`/`tx_ready` into `tx_uart` → `rx_uart` loopback at the default `GAP_CYCLES` → the received byte sequence equals 0x73, op_a, 0x73, op_b with no overruns.
